reg_bank_rd: RTL and testbench
==============================

// Module: reg_bank_rd
// PURPOSE
//  32x32 general-purpose register bank. Consumes the 5-bit write index produced by the
//  write-register select mux (rt / sp=29 / ra=31 / rd) plus the write-back data.
//  Serves the two operand read ports (rs, rt) to the ALU/datapath.
//  Sits between the write-back muxes and the A/B operand registers of the multicycle CPU.
//  Reads are registered: one-cycle latency, with a valid strobe.
// PARAMETERS
//  DATA_W    32   register width
//  ADDR_W    5    register index width (2**ADDR_W registers)
//  SP_IDX    29   stack pointer index
//  SP_RESET  227  stack pointer value after reset
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       synchronous, active-high reset
//  wr_en     in   1       write strobe (RegWrite from control unit)
//  wr_addr   in   ADDR_W  destination index from write-register select mux
//  wr_data   in   DATA_W  write-back data
//  rd_req    in   1       capture a new operand pair this cycle
//  rs_addr   in   ADDR_W  read index A (instr[25:21])
//  rt_addr   in   ADDR_W  read index B (instr[20:16])
//  rs_data   out  DATA_W  registered operand A
//  rt_data   out  DATA_W  registered operand B
//  rd_valid  out  1       high one cycle after an accepted rd_req
//  sp_data   out  DATA_W  current value of reg[SP_IDX], registered-state view
// BEHAVIOUR
//  Reset
//  - On any rising edge with reset=1: every reg := 0, except reg[SP_IDX] := SP_RESET.
//  - Outputs after that edge: rs_data=0, rt_data=0, rd_valid=0, sp_data=SP_RESET.
//  - Reset overrides wr_en and rd_req in the same cycle.
//  - A reset asserted mid-read cancels the pending rd_valid.
//  Write
//  - On an edge with wr_en=1 and wr_addr!=0: reg[wr_addr] := wr_data.
//  - Writes to index 0 are discarded; reg[0] reads 0 always.
//  Read (latency 1)
//  - On an edge with rd_req=1, rs_data/rt_data capture the addressed registers.
//  - Write-first bypass: if wr_en=1 and wr_addr==rs_addr!=0 in the same cycle,
//    rs_data captures wr_data, not the old value. Same rule for rt.
//  - Index 0 returns 0 even when bypass conditions match (wr_addr=0).
//  - rs_addr==rt_addr is legal; both outputs get the same value.
//  - rd_valid := rd_req on every non-reset edge.
//  - With rd_req=0, rs_data/rt_data hold their last value.
//  - sp_data is reg[SP_IDX] itself. A write to SP is visible on sp_data from the next cycle.
//  Widths: no arithmetic. All indices are unsigned.
//    Indices >= 2**ADDR_W are impossible by construction.
// TESTING
//  1. reset=1 for one edge, then rd_req with rs=29, rt=0
//     -> rs_data=227, rt_data=0, rd_valid=1 one cycle later.
//  2. wr_en, wr_addr=31, wr_data=0x0040_0010; next cycle rd_req with rs=31
//     -> rs_data=0x0040_0010 after one edge.
//  3. Same-cycle wr_en (addr=8, data=0xDEAD_BEEF) and rd_req (rs=8, rt=8)
//     -> rs_data=rt_data=0xDEAD_BEEF (bypass).
//  4. wr_en, wr_addr=0, wr_data=0xFFFF_FFFF with rd_req rs=0
//     -> rs_data=0; a later read of reg 0 also gives 0.
//  5. rd_req=1 then rd_req=0 for 3 cycles while writing reg 8
//     -> rs_data holds the old value, rd_valid=0 for those cycles.
//  6. rd_req asserted together with reset=1, and reg[5] previously written
//     -> rd_valid=0, rs_data=0, all regs cleared, sp_data=227.

Source files
------------

// File: rtl/reg_bank_rd_if.sv
// Write-back / operand-read bundle of the 32x32 register bank.
// The master drives writes and read requests; the slave returns registered operands.
interface reg_bank_rd_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              rd_valid;
   logic [DATA_W-1:0] sp_data;

   modport master (
      output wr_en, wr_addr, wr_data, rd_req, rs_addr, rt_addr,
      input  rs_data, rt_data, rd_valid, sp_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_req, rs_addr, rt_addr,
      output rs_data, rt_data, rd_valid, sp_data
   );
endinterface

// File: rtl/reg_bank_rd.sv
// General-purpose register bank with write-first bypass and registered operand reads.
// Register 0 is hard-wired to zero; the stack pointer has a non-zero reset value.
module reg_bank_rd #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 5,
   parameter int                SP_IDX   = 29,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(32'd227)
) (
   input logic           clk,
   input logic           reset,
   reg_bank_rd_if.slave  bus
);
   localparam int                NREG = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic              rd_valid_q, rd_valid_d;

   // Operand selection: index 0 is always zero, a same-cycle write to the index wins.
   function automatic logic [DATA_W-1:0] operand(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              wen,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] val;
      if (addr == {ADDR_W{1'b0}}) begin
         val = {DATA_W{1'b0}};
      end else if (wen && (waddr == addr)) begin
         val = wdata;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // Next state of the register array
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         if (i == 0) begin
            regs_d[i] = {DATA_W{1'b0}};
         end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
            regs_d[i] = bus.wr_data;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Next state of the operand outputs and their valid strobe
   always_comb begin
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      rd_valid_d = bus.rd_req;
      if (bus.rd_req) begin
         rs_data_d = operand(bus.rs_addr, regs_q[bus.rs_addr],
                             bus.wr_en, bus.wr_addr, bus.wr_data);
         rt_data_d = operand(bus.rt_addr, regs_q[bus.rt_addr],
                             bus.wr_en, bus.wr_addr, bus.wr_data);
      end else begin
         rs_data_d = rs_data_q;
         rt_data_d = rt_data_q;
      end
   end

   // State registers; reset wins over any write or read in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == SP_IDX) ? SP_RESET : {DATA_W{1'b0}};
         end
         rs_data_q  <= {DATA_W{1'b0}};
         rt_data_q  <= {DATA_W{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.rs_data  = rs_data_q;
   assign bus.rt_data  = rt_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.sp_data  = regs_q[SP_A];
endmodule

// File: tb/tb_reg_bank_rd.sv
// Directed scoreboard bench for reg_bank_rd: stimulus pushes hand-computed expectations,
// a monitor pops one entry per clock edge and compares every output.
module tb_reg_bank_rd;
   logic clk;
   logic reset;

   reg_bank_rd_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   reg_bank_rd dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        v;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] sp;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int vec, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec=%0d actual=%h required=%h", name, vec, act, req);
      end
   endtask

   // Monitor: one expectation per edge, sampled just after the edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         vec_no++;
         chk("rd_valid", vec_no, {31'd0, bus.rd_valid}, {31'd0, mon_e.v});
         chk("sp_data",  vec_no, bus.sp_data, mon_e.sp);
         chk("rs_data",  vec_no, bus.rs_data, mon_e.rs);
         chk("rt_data",  vec_no, bus.rt_data, mon_e.rt);
      end
   end

   task automatic step(
      input logic        rst,
      input logic        wen,
      input logic [4:0]  waddr,
      input logic [31:0] wdata,
      input logic        req,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic        e_v,
      input logic [31:0] e_rs,
      input logic [31:0] e_rt,
      input logic [31:0] e_sp
   );
      exp_t e;
      @(negedge clk);
      reset       = rst;
      bus.wr_en   = wen;
      bus.wr_addr = waddr;
      bus.wr_data = wdata;
      bus.rd_req  = req;
      bus.rs_addr = rs;
      bus.rt_addr = rt;
      e.v  = e_v;
      e.rs = e_rs;
      e.rt = e_rt;
      e.sp = e_sp;
      exp_q.push_back(e);
   endtask

   initial begin
      reset       = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = 5'd0;
      bus.wr_data = 32'd0;
      bus.rd_req  = 1'b0;
      bus.rs_addr = 5'd0;
      bus.rt_addr = 5'd0;

      //   rst   wen   waddr  wdata          req   rs     rt     v     rs             rt             sp
      step(1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd29, 5'd0,  1'b1, 32'd227,       32'h0000_0000, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  5'd0,  1'b0, 32'd227,       32'h0000_0000, 32'd227);
      step(1'b0, 1'b1, 5'd31, 32'h0040_0010, 1'b0, 5'd0,  5'd0,  1'b0, 32'd227,       32'h0000_0000, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd31, 5'd29, 1'b1, 32'h0040_0010, 32'd227,       32'd227);
      // same-cycle write and read of reg 8 on both ports
      step(1'b0, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b1, 5'd8,  5'd8,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd227);
      // write to reg 0 is dropped, even for the bypass path
      step(1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  5'd31, 1'b1, 32'h0000_0000, 32'h0040_0010, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  5'd0,  1'b1, 32'h0000_0000, 32'h0000_0000, 32'd227);
      // read once, then hold for three cycles while reg 8 is rewritten
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd8,  5'd29, 1'b1, 32'hDEAD_BEEF, 32'd227,       32'd227);
      step(1'b0, 1'b1, 5'd8,  32'h1111_1111, 1'b0, 5'd8,  5'd8,  1'b0, 32'hDEAD_BEEF, 32'd227,       32'd227);
      step(1'b0, 1'b1, 5'd8,  32'h2222_2222, 1'b0, 5'd8,  5'd8,  1'b0, 32'hDEAD_BEEF, 32'd227,       32'd227);
      step(1'b0, 1'b1, 5'd8,  32'h3333_3333, 1'b0, 5'd8,  5'd8,  1'b0, 32'hDEAD_BEEF, 32'd227,       32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd8,  5'd0,  1'b1, 32'h3333_3333, 32'h0000_0000, 32'd227);
      // SP write: bypassed onto rs, visible on sp_data after the edge
      step(1'b0, 1'b1, 5'd29, 32'h0000_1000, 1'b1, 5'd29, 5'd1,  1'b1, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000);
      step(1'b0, 1'b1, 5'd3,  32'h0000_0003, 1'b1, 5'd1,  5'd3,  1'b1, 32'h0000_0000, 32'h0000_0003, 32'h0000_1000);
      step(1'b0, 1'b1, 5'd5,  32'h55AA_55AA, 1'b1, 5'd5,  5'd8,  1'b1, 32'h55AA_55AA, 32'h3333_3333, 32'h0000_1000);
      // reset with a read and write pending: everything cleared, no valid
      step(1'b1, 1'b1, 5'd5,  32'h7777_7777, 1'b1, 5'd5,  5'd29, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd5,  5'd8,  1'b1, 32'h0000_0000, 32'h0000_0000, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd29, 5'd31, 1'b1, 32'd227,       32'h0000_0000, 32'd227);
      step(1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd3,  5'd0,  1'b1, 32'h0000_0000, 32'h0000_0000, 32'd227);

      for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
         @(negedge clk);
      end
      bus.rd_req = 1'b0;
      bus.wr_en  = 1'b0;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
